// File: rtl/bmc_soft_pipe_if.sv
// Branch-metric transfer bundle: upstream branch handshake in, metric handshake out.
interface bmc_soft_pipe_if #(
  parameter int NSYM = 2,
  parameter int SW   = 3,
  parameter int MW   = $clog2(NSYM * (2**SW - 1) + 1)
);
  logic                      in_valid;
  logic                      in_ready;
  logic [NSYM*SW-1:0]        rx_sym;
  logic [NSYM-1:0]           erase;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [(2**NSYM)*MW-1:0]   bm;
  logic                      out_last;
  logic [15:0]               branch_cnt;

  modport slave (
    input  in_valid, rx_sym, erase, in_last, out_ready,
    output in_ready, out_valid, bm, out_last, branch_cnt
  );

  modport master (
    output in_valid, rx_sym, erase, in_last, out_ready,
    input  in_ready, out_valid, bm, out_last, branch_cnt
  );
endinterface

// File: rtl/bmc_soft_pipe.sv
// Soft/hard-decision branch metric unit: per-symbol distances in stage 1,
// all 2**NSYM hypothesis sums in stage 2, plus a per-frame branch counter.
module bmc_soft_pipe #(
  parameter int NSYM = 2,
  parameter int SW   = 3,
  parameter int MW   = $clog2(NSYM * (2**SW - 1) + 1)
) (
  input logic            clk,
  input logic            rst_n,
  bmc_soft_pipe_if.slave bus
);
  localparam int NH = 2**NSYM;
  localparam logic [SW-1:0] SMAX = '1;

  logic [SW-1:0]      d0_q [NSYM];
  logic [SW-1:0]      d0_d [NSYM];
  logic [SW-1:0]      d1_q [NSYM];
  logic [SW-1:0]      d1_d [NSYM];
  logic               s1_valid_q, s1_valid_d;
  logic               s1_last_q, s1_last_d;
  logic [NH*MW-1:0]   bm_q, bm_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [15:0]        branch_cnt_q, branch_cnt_d;
  logic [MW-1:0]      acc;

  logic s2_adv, s1_adv, in_hs, out_hs;

  assign s2_adv = ~out_valid_q | bus.out_ready;
  assign s1_adv = ~s1_valid_q | s2_adv;
  assign in_hs  = bus.in_valid & s1_adv;
  assign out_hs = out_valid_q & bus.out_ready;

  // d0 is the distance assuming code bit 0, d1 assuming code bit 1.
  always_comb begin
    d0_d       = d0_q;
    d1_d       = d1_q;
    s1_last_d  = s1_last_q;
    s1_valid_d = s1_adv ? bus.in_valid : s1_valid_q;
    if (in_hs) begin
      s1_last_d = bus.in_last;
      for (int unsigned i = 0; i < NSYM; i++) begin
        d0_d[i] = bus.erase[i] ? '0 : bus.rx_sym[i*SW +: SW];
        d1_d[i] = bus.erase[i] ? '0 : SMAX - bus.rx_sym[i*SW +: SW];
      end
    end
  end

  always_comb begin
    bm_d        = bm_q;
    out_last_d  = out_last_q;
    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
    acc         = '0;
    if (s2_adv && s1_valid_q) begin
      out_last_d = s1_last_q;
      for (int unsigned h = 0; h < NH; h++) begin
        acc = '0;
        for (int unsigned i = 0; i < NSYM; i++) begin
          acc = acc + MW'(h[i] ? d1_q[i] : d0_q[i]);
        end
        bm_d[h*MW +: MW] = acc;
      end
    end
  end

  // End-of-frame clear overrides the increment of that same handshake.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    if (out_hs) begin
      if (out_last_q) begin
        branch_cnt_d = '0;
      end else if (branch_cnt_q != '1) begin
        branch_cnt_d = branch_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d0_q         <= '{default: '0};
      d1_q         <= '{default: '0};
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      bm_q         <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      branch_cnt_q <= '0;
    end else begin
      d0_q         <= d0_d;
      d1_q         <= d1_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      bm_q         <= bm_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  assign bus.in_ready   = s1_adv;
  assign bus.out_valid  = out_valid_q;
  assign bus.bm         = bm_q;
  assign bus.out_last   = out_last_q;
  assign bus.branch_cnt = branch_cnt_q;
endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Directed bench for bmc_soft_pipe: soft (SW=3) and hard (SW=1) instances.
module tb_bmc_soft_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bmc_soft_pipe_if #(.NSYM(2), .SW(3)) a_if ();
  bmc_soft_pipe_if #(.NSYM(2), .SW(1)) b_if ();

  bmc_soft_pipe #(.NSYM(2), .SW(3)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  bmc_soft_pipe #(.NSYM(2), .SW(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference metric for NSYM=2, SW=3 (MW=4).
  function automatic logic [15:0] bm_ref(input logic [5:0] rx, input logic [1:0] er);
    logic [15:0] r;
    int          sum, s, d;
    r = '0;
    for (int h = 0; h < 4; h++) begin
      sum = 0;
      for (int i = 0; i < 2; i++) begin
        s = int'(rx[i*3 +: 3]);
        d = ((h >> i) & 1) != 0 ? 7 - s : s;
        if (er[i]) d = 0;
        sum += d;
      end
      r[h*4 +: 4] = sum[3:0];
    end
    return r;
  endfunction

  typedef struct packed {
    logic [15:0] bm;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          log_q[$];
  int          mdl_cnt = 0;
  int          n_out = 0;
  logic        prev_hs = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_bm = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      mdl_cnt    = 0;
      prev_hs    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("cnt", 32'(a_if.branch_cnt), 32'(mdl_cnt));
      if (prev_hs) log_q.push_back(int'(a_if.branch_cnt));
      if (prev_stall) begin
        chk("hold_valid", 32'(a_if.out_valid), 32'd1);
        chk("hold_bm", 32'(a_if.bm), 32'(prev_bm));
        chk("hold_last", 32'(a_if.out_last), 32'(prev_last));
      end
      prev_hs    = a_if.out_valid && a_if.out_ready;
      prev_stall = a_if.out_valid && !a_if.out_ready;
      prev_bm    = a_if.bm;
      prev_last  = a_if.out_last;
      if (prev_hs) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
          e.last = a_if.out_last;
        end else begin
          e = exp_q.pop_front();
          chk("bm", 32'(a_if.bm), 32'(e.bm));
          chk("last", 32'(a_if.out_last), 32'(e.last));
        end
        if (e.last) mdl_cnt = 0;
        else if (mdl_cnt < 65535) mdl_cnt++;
      end
      if (a_if.in_valid && a_if.in_ready)
        exp_q.push_back('{bm: bm_ref(a_if.rx_sym, a_if.erase), last: a_if.in_last});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a branch and returns just after the edge that accepted it.
  task automatic send(input logic [5:0] rx, input logic [1:0] er, input logic last);
    bit done;
    done = 1'b0;
    a_if.in_valid = 1'b1;
    a_if.rx_sym   = rx;
    a_if.erase    = er;
    a_if.in_last  = last;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (a_if.in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int k;
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || a_if.out_valid) && k < 100) begin
      step();
      k++;
    end
    if (k >= 100) chk("drain_timeout", 32'd0, 32'd1);
    step();
  endtask

  logic [5:0] rx_tab [8] = '{6'o07, 6'o70, 6'o25, 6'o52, 6'o33, 6'o61, 6'o14, 6'o46};
  logic [1:0] er_tab [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd3, 2'd0, 2'd1};
  logic [7:0] ham_tab [4] = '{8'h94, 8'h61, 8'h49, 8'h16};
  int         exp5 [7] = '{1, 2, 3, 4, 0, 1, 2};

  initial begin
    int base;
    a_if.in_valid = 1'b0; a_if.rx_sym = '0; a_if.erase = '0; a_if.in_last = 1'b0;
    a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.rx_sym = '0; b_if.erase = '0; b_if.in_last = 1'b0;
    b_if.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("rst_valid", 32'(a_if.out_valid), 32'd0);
    chk("rst_bm", 32'(a_if.bm), 32'd0);
    chk("rst_last", 32'(a_if.out_last), 32'd0);
    chk("rst_cnt", 32'(a_if.branch_cnt), 32'd0);
    chk("rst_ready", 32'(a_if.in_ready), 32'd1);
    chk("rst_b_valid", 32'(b_if.out_valid), 32'd0);
    chk("rst_b_bm", 32'(b_if.bm), 32'd0);

    // Hard-decision instance: Hamming metrics for every received pair.
    for (int rx = 0; rx < 4; rx++) begin
      b_if.rx_sym   = 2'(rx);
      b_if.in_valid = 1'b1;
      step();
      b_if.in_valid = 1'b0;
      step();
      chk("ham_valid", 32'(b_if.out_valid), 32'd1);
      chk("ham_bm", 32'(b_if.bm), 32'(ham_tab[rx]));
    end

    // Single soft branch, held at the output with out_ready low.
    send(6'o70, 2'b00, 1'b0);
    a_if.in_valid = 1'b0;
    step();
    chk("t1_valid", 32'(a_if.out_valid), 32'd1);
    chk("t1_bm", 32'(a_if.bm), 32'h70E7);
    step();
    chk("t1_bm_held", 32'(a_if.bm), 32'h70E7);
    a_if.out_ready = 1'b1;
    step();
    chk("t1_done", 32'(a_if.out_valid), 32'd0);
    chk("t1_cnt", 32'(a_if.branch_cnt), 32'd1);

    // Erasures, back to back.
    send(6'o70, 2'b10, 1'b0);
    send(6'o70, 2'b11, 1'b0);
    a_if.in_valid = 1'b0;
    chk("t2_bm_er10", 32'(a_if.bm), 32'h7070);
    step();
    chk("t2_bm_er11", 32'(a_if.bm), 32'h0000);
    drain();

    // Eight-branch stream with an output stall.
    base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rx_tab[i], er_tab[i], 1'b0);
        a_if.in_valid = 1'b0;
      end
      begin
        step();
        step();
        a_if.out_ready = 1'b0;
        step();
        chk("t4_ready_full", 32'(a_if.in_ready), 32'd0);
        chk("t4_valid_stall", 32'(a_if.out_valid), 32'd1);
        step();
        chk("t4_ready_full2", 32'(a_if.in_ready), 32'd0);
        step();
        a_if.out_ready = 1'b1;
      end
    join
    drain();
    chk("t4_out_count", 32'(n_out - base), 32'd8);
    chk("t4_cnt", 32'(a_if.branch_cnt), 32'd11);

    // Fresh frame after reset: 5 branches ending in last, then 2 more.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_rst_cnt", 32'(a_if.branch_cnt), 32'd0);
    log_q.delete();
    for (int i = 0; i < 5; i++) send(rx_tab[i], er_tab[i], i == 4);
    for (int i = 5; i < 7; i++) send(rx_tab[i], er_tab[i], 1'b0);
    drain();
    chk("t5_log_len", 32'(log_q.size()), 32'd7);
    for (int i = 0; i < 7 && i < log_q.size(); i++) chk("t5_log", 32'(log_q[i]), 32'(exp5[i]));

    // Saturation at 16'hFFFF, then clear by last.
    for (int k = 0; k < 65533; k++) send(6'o07, 2'b00, 1'b0);
    drain();
    chk("sat_reach", 32'(a_if.branch_cnt), 32'hFFFF);
    send(6'o52, 2'b00, 1'b0);
    drain();
    chk("sat_hold", 32'(a_if.branch_cnt), 32'hFFFF);
    send(6'o25, 2'b00, 1'b1);
    drain();
    chk("sat_clear", 32'(a_if.branch_cnt), 32'd0);
    send(6'o33, 2'b00, 1'b0);
    drain();
    chk("pre_rst_cnt", 32'(a_if.branch_cnt), 32'd1);

    // One-cycle reset with two branches in flight.
    send(6'o61, 2'b00, 1'b0);
    send(6'o16, 2'b01, 1'b0);
    a_if.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_valid", 32'(a_if.out_valid), 32'd0);
    chk("t6_cnt", 32'(a_if.branch_cnt), 32'd0);
    chk("t6_ready", 32'(a_if.in_ready), 32'd1);
    base = n_out;
    repeat (5) step();
    chk("t6_no_ghost", 32'(n_out - base), 32'd0);
    log_q.delete();
    send(6'o44, 2'b00, 1'b1);
    drain();
    chk("t6_single_len", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) chk("t6_single_cnt", 32'(log_q[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
